unidade_controle: RTL

UNIDADE_CONTROLE -- requirements
Module: unidade_controle
Interface
REQ-001 The module SHALL have no parameters; all timing comes from datapath status inputs.
REQ-002 clock  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces state inicial immediately.
REQ-004 iniciar  in  1  level; starts a game from inicial or any fim_* state.
REQ-005 confirma  in  1  level; accepts the mode shown in escolhe_modo.
REQ-006 acertouJogada  in  1  registered play matches expected pattern.
REQ-007 jogadaAtualEQUALSacertoAnterior  in  1  play equals last registered hit.
REQ-008 tem_jogada  in  1  one-cycle pulse on new button press.
REQ-009 fimS, fimLedsOn, fimLedsOff, fimPiscaLeds, timeout  in  1 each  datapath end-of-count flags.
REQ-010 zeraT, zeraS, zeraR, zeraA, zeraL, zeraM  out  1 each  datapath clears.
REQ-011 contaT, contaS, contaA, contaM, contaLedsOn, contaLedsOff, contaPiscadas  out  1 each  counter enables.
REQ-012 registraR, registraA, registraL  out  1 each  register loads.
REQ-013 displayFromMem  out  1  HEX3-5 show message memory, not timer.
REQ-014 displayAddr  out  2  message select: 0 mode, 1 win, 2 lose, 3 timeout.
REQ-015 apagarAcertos  out  1  blanks hit LEDs.
REQ-016 db_estado  out  4  current state encoding, debug.
Function
REQ-017 Moore FSM; all outputs SHALL be decoded from state only, default 0 in every state unless listed.
REQ-018 Encodings SHALL be: inicial 0, preparacao 1, escolhe_modo 2, mostra_on 3, mostra_off 4, espera 5, registra 6, compara 7, conta_acerto 8, proxima 9, fim_acertou A, fim_errou B, fim_timeout C, pisca_on D, pisca_off E.
REQ-019 inicial: apagarAcertos=1; iniciar -> preparacao.
REQ-020 preparacao (1 cycle): all six zera* =1 -> escolhe_modo.
REQ-021 escolhe_modo: contaM=1, displayFromMem=1, displayAddr=0; confirma -> mostra_on.
REQ-022 mostra_on: registraL=1, contaLedsOn=1; fimLedsOn -> mostra_off.
REQ-023 mostra_off: contaLedsOff=1, zeraL=1; fimLedsOff -> espera.
REQ-024 espera: contaT=1; timeout -> fim_timeout (priority over tem_jogada in same cycle); else tem_jogada -> registra.
REQ-025 registra (1 cycle): registraR=1, contaT=1 -> compara.
REQ-026 compara (1 cycle): contaT=1; !acertouJogada -> fim_errou; acertouJogada & jogadaAtualEQUALSacertoAnterior -> espera; else -> conta_acerto.
REQ-027 conta_acerto (1 cycle): registraA=1, contaA=1 -> proxima.
REQ-028 proxima (1 cycle): fimS -> fim_acertou; else contaS=1, zeraT=1, zeraR=1 -> mostra_on.
REQ-029 fim_acertou/fim_errou/fim_timeout: displayFromMem=1, displayAddr=1/2/3; iniciar -> preparacao; outputs held otherwise.
REQ-030 Unused encodings (F) SHALL return to inicial on the next edge.
Reset
REQ-031 Asserting reset (low) at any time, including mid-round, SHALL set state inicial and db_estado=0 asynchronously; outputs then equal inicial decode (apagarAcertos=1, all others 0).
REQ-032 Release SHALL be sampled on the next rising edge; no transition occurs in the release cycle unless iniciar is high.
Configuration
REQ-033 Macro PISCA_FIM_EN defined: fim_acertou SHALL go unconditionally to pisca_on; pisca_on drives contaLedsOn=1, contaPiscadas=1, displayFromMem=1, displayAddr=1, -> pisca_off on fimLedsOn; pisca_off drives contaLedsOff=1, apagarAcertos=1, displayFromMem=1, displayAddr=1, -> fim_acertou-hold (stays in pisca_off outputs cleared) on fimPiscaLeds, else -> pisca_on on fimLedsOff; iniciar from pisca states -> preparacao.
REQ-034 Macro undefined: pisca_on/pisca_off SHALL not exist (treated as unused encodings) and fim_acertou holds as in REQ-029.
Verification
REQ-035 reset low, iniciar=1 -> db_estado=0, apagarAcertos=1; release, next edge -> 1, next -> 2 with zera* high exactly one cycle.
REQ-036 In espera, pulse tem_jogada with acertouJogada=1, jogadaAtual!=anterior -> db_estado 6,7,8,9 on consecutive edges, contaA high one cycle.
REQ-037 In espera, timeout=1 and tem_jogada=1 same cycle -> next db_estado=C, displayAddr=3.
REQ-038 compara with acertouJogada=0 -> db_estado=B, displayAddr=2, displayFromMem=1.
REQ-039 proxima with fimS=1 -> db_estado=A; with PISCA_FIM_EN, 3 fimLedsOn/fimLedsOff pairs then fimPiscaLeds -> contaPiscadas high 3 times, ends in pisca_off with outputs cleared.
REQ-040 Assert reset in mostra_on mid-count -> db_estado=0 before next edge, contaLedsOn=0.

---
 rtl/unidade_controle.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// unidade_controle: Moore control FSM for the memory/pattern game.
// All outputs are decoded from the current state (plus the blink-done flag
// when the end-of-game blink is built in).
// Optional build macro: PISCA_FIM_EN adds the end-of-game LED blink states
// pisca_on/pisca_off after fim_acertou.
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirma,
  input  logic       acertouJogada,
  input  logic       jogadaAtualEQUALSacertoAnterior,
  input  logic       tem_jogada,
  input  logic       fimS,
  input  logic       fimLedsOn,
  input  logic       fimLedsOff,
  input  logic       fimPiscaLeds,
  input  logic       timeout,
  output logic       zeraT,
  output logic       zeraS,
  output logic       zeraR,
  output logic       zeraA,
  output logic       zeraL,
  output logic       zeraM,
  output logic       contaT,
  output logic       contaS,
  output logic       contaA,
  output logic       contaM,
  output logic       contaLedsOn,
  output logic       contaLedsOff,
  output logic       contaPiscadas,
  output logic       registraR,
  output logic       registraA,
  output logic       registraL,
  output logic       displayFromMem,
  output logic [1:0] displayAddr,
  output logic       apagarAcertos,
  output logic [3:0] db_estado
);

  // pisca_on/pisca_off are only reachable when PISCA_FIM_EN is defined;
  // otherwise they decode like the unused code F.
  typedef enum logic [3:0] {
    inicial     = 4'h0,
    preparacao  = 4'h1,
    escolheModo = 4'h2,
    mostraOn    = 4'h3,
    mostraOff   = 4'h4,
    espera      = 4'h5,
    registra    = 4'h6,
    compara     = 4'h7,
    contaAcerto = 4'h8,
    proxima     = 4'h9,
    fimAcertou  = 4'hA,
    fimErrou    = 4'hB,
    fimTimeout  = 4'hC,
    piscaOn     = 4'hD,
    piscaOff    = 4'hE
  } estado_t;

  estado_t estadoAtual;
  estado_t estadoNext;

`ifdef PISCA_FIM_EN
  // Set once the blink sequence is over: pisca_off is then held with all
  // outputs cleared until a new game is started.
  logic piscaFeito;

  // Blink-done flag: set on fimPiscaLeds in pisca_off, kept while held there.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) piscaFeito <= 1'b0;
    else        piscaFeito <= (estadoAtual == piscaOff) && (estadoNext == piscaOff) &&
                              (piscaFeito || fimPiscaLeds);
  end
`else
  logic unusedPisca;
  assign unusedPisca = fimPiscaLeds;
`endif

  // State register; reset forces inicial immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estadoAtual <= inicial;
    else        estadoAtual <= estadoNext;
  end

  // Next-state logic.
  always_comb begin
    estadoNext = estadoAtual;
    case (estadoAtual)
      inicial:     if (iniciar) estadoNext = preparacao;
      preparacao:  estadoNext = escolheModo;
      escolheModo: if (confirma) estadoNext = mostraOn;
      mostraOn:    if (fimLedsOn) estadoNext = mostraOff;
      mostraOff:   if (fimLedsOff) estadoNext = espera;
      espera: begin
        // timeout wins over a simultaneous button press
        if (timeout)         estadoNext = fimTimeout;
        else if (tem_jogada) estadoNext = registra;
      end
      registra:    estadoNext = compara;
      compara: begin
        if (!acertouJogada)                       estadoNext = fimErrou;
        else if (jogadaAtualEQUALSacertoAnterior) estadoNext = espera;
        else                                      estadoNext = contaAcerto;
      end
      contaAcerto: estadoNext = proxima;
      proxima:     estadoNext = fimS ? fimAcertou : mostraOn;
`ifdef PISCA_FIM_EN
      fimAcertou:  estadoNext = iniciar ? preparacao : piscaOn;
      piscaOn: begin
        if (iniciar)        estadoNext = preparacao;
        else if (fimLedsOn) estadoNext = piscaOff;
      end
      piscaOff: begin
        if (iniciar)                         estadoNext = preparacao;
        else if (piscaFeito || fimPiscaLeds) estadoNext = piscaOff;
        else if (fimLedsOff)                 estadoNext = piscaOn;
      end
`else
      fimAcertou:  if (iniciar) estadoNext = preparacao;
`endif
      fimErrou:    if (iniciar) estadoNext = preparacao;
      fimTimeout:  if (iniciar) estadoNext = preparacao;
      default:     estadoNext = inicial;
    endcase
  end

  // Output decode from state; the proxima clears are harmless when the
  // round ends because the fim states do not use timer/play registers.
  always_comb begin
    zeraT = 1'b0; zeraS = 1'b0; zeraR = 1'b0; zeraA = 1'b0; zeraL = 1'b0; zeraM = 1'b0;
    contaT = 1'b0; contaS = 1'b0; contaA = 1'b0; contaM = 1'b0;
    contaLedsOn = 1'b0; contaLedsOff = 1'b0; contaPiscadas = 1'b0;
    registraR = 1'b0; registraA = 1'b0; registraL = 1'b0;
    displayFromMem = 1'b0; displayAddr = 2'd0; apagarAcertos = 1'b0;
    case (estadoAtual)
      inicial:     apagarAcertos = 1'b1;
      preparacao: begin
        zeraT = 1'b1; zeraS = 1'b1; zeraR = 1'b1;
        zeraA = 1'b1; zeraL = 1'b1; zeraM = 1'b1;
      end
      escolheModo: begin contaM = 1'b1; displayFromMem = 1'b1; displayAddr = 2'd0; end
      mostraOn:    begin registraL = 1'b1; contaLedsOn = 1'b1; end
      mostraOff:   begin contaLedsOff = 1'b1; zeraL = 1'b1; end
      espera:      contaT = 1'b1;
      registra:    begin registraR = 1'b1; contaT = 1'b1; end
      compara:     contaT = 1'b1;
      contaAcerto: begin registraA = 1'b1; contaA = 1'b1; end
      proxima:     begin contaS = 1'b1; zeraT = 1'b1; zeraR = 1'b1; end
      fimAcertou:  begin displayFromMem = 1'b1; displayAddr = 2'd1; end
      fimErrou:    begin displayFromMem = 1'b1; displayAddr = 2'd2; end
      fimTimeout:  begin displayFromMem = 1'b1; displayAddr = 2'd3; end
`ifdef PISCA_FIM_EN
      piscaOn: begin
        contaLedsOn = 1'b1; contaPiscadas = 1'b1;
        displayFromMem = 1'b1; displayAddr = 2'd1;
      end
      piscaOff: begin
        if (!piscaFeito) begin
          contaLedsOff = 1'b1; apagarAcertos = 1'b1;
          displayFromMem = 1'b1; displayAddr = 2'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign db_estado = estadoAtual;

endmodule
